multicycle_ctrl_fsm: RTL

Main sequencing controller for the multicycle ARM datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the mux selects, write enables and ALU-op request that steer the PC, instruction register, A/B operand register pair, ALUOut and data registers. It adds a request/ready handshake to the shared instruction/data memory, plus a wait-timeout watchdog.

---
 rtl/multicycle_ctrl_fsm.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencing FSM for the multicycle ARM datapath: fetch/decode/execute/mem/writeback,
// with a request/ready handshake to the shared memory and a watchdog on memory waits.
module multicycle_ctrl_fsm #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       irwrite,
    output logic       nextpc,
    output logic       regw,
    output logic       memw,
    output logic       branch,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       aluop,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_e;

    localparam bit             WDOG_EN  = (WAIT_LIMIT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               wait_st;
    logic               timeout;
    logic               unused_funct;

    // Only the I bit and the L bit of funct steer the sequence.
    assign unused_funct = ^funct[4:1];

    always_comb begin
        wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout = WDOG_EN && wait_st && !mem_ready && (wait_cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_UNKNOWN:  state_d = S_UNKNOWN;
            default:    state_d = S_UNKNOWN;
        endcase
        // A ready on the last allowed cycle already moved us on, so timeout never fires then.
        if (timeout) state_d = S_UNKNOWN;
    end

    // Counter only survives a cycle that stalls in a wait state; any move or ready clears it.
    always_comb begin
        wait_cnt_d = '0;
        if (wait_st && !mem_ready && (state_d == state_q))
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        irwrite   = 1'b0;
        nextpc    = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        adrsrc    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        aluop     = 1'b0;
        fault     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                nextpc    = mem_ready;
            end
            S_DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
            S_MEMADR: begin
                alusrcb = 2'b01;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regw      = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
                memw    = 1'b1;
            end
            S_EXECUTER: begin
                aluop = 1'b1;
            end
            S_EXECUTEI: begin
                alusrcb = 2'b01;
                aluop   = 1'b1;
            end
            S_ALUWB: begin
                regw = 1'b1;
            end
            S_BRANCH: begin
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                branch    = 1'b1;
            end
            S_UNKNOWN: begin
                fault = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
